// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS I/O path: datapath width and I/O FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_PRESS   = 2'd1,
      WAIT_RELEASE = 2'd2,
      DONE         = 2'd3
   } io_state_e;

endpackage

// File: rtl/debouncer.sv
// Two-flop synchronizer plus stability counter for a bouncing push button.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles before level_o follows.
// Backpressure: none; free-running, samples every cycle.
module debouncer #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clock,
   input  logic reset,
   input  logic raw_i,
   output logic level_o
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q;
   logic             level_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Count consecutive disagreeing samples; any agreeing sample restarts the count.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end
   end

   // Synchronizer chain, counter and accepted level registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/io_unit.sv
// CPU I/O unit: IN waits for a confirm press/release and captures switches; OUT latches display.
// Latency: IN completes one cycle after debounced release; OUT updates display on the issuing edge.
// Backpressure: stall holds the CPU for the whole IN handshake except the single DONE cycle.
module io_unit
   import mips_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int SW_WIDTH        = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                FLAG_input,
   input  logic                FLAG_output,
   input  logic [DATA_W-1:0]   data_out,
   input  logic [SW_WIDTH-1:0] switches,
   input  logic                confirm,
   output logic [DATA_W-1:0]   data_in,
   output logic                stall,
   output logic [DATA_W-1:0]   display,
   output logic                output_strobe
);

   io_state_e         state_q;
   io_state_e         state_d;
   logic [DATA_W-1:0] data_in_q;
   logic [DATA_W-1:0] data_in_d;
   logic [DATA_W-1:0] display_q;
   logic [DATA_W-1:0] display_d;
   logic              strobe_q;
   logic              strobe_d;
   logic              btn_level;

   debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clock  (clock),
      .reset  (reset),
      .raw_i  (confirm),
      .level_o(btn_level)
   );

   // Handshake FSM, switch capture and OUT latch; the IN path wins over OUT.
   always_comb begin
      state_d   = state_q;
      data_in_d = data_in_q;
      display_d = display_q;
      strobe_d  = 1'b0;
      stall     = FLAG_input && (state_q != DONE) && !reset;

      case (state_q)
         IDLE: begin
            if (FLAG_input) begin
               state_d = WAIT_PRESS;
            end
         end
         WAIT_PRESS: begin
            // A button already held is accepted here without needing a re-press.
            if (btn_level) begin
               state_d   = WAIT_RELEASE;
               data_in_d = DATA_W'(switches);
            end
         end
         WAIT_RELEASE: begin
            if (!btn_level) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // Single unstalled cycle: the CPU commits data_in and advances PC.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (FLAG_output && !FLAG_input && !stall) begin
         display_d = data_out;
         strobe_d  = 1'b1;
      end
   end

   // State and output registers; reset aborts any capture in progress.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         data_in_q <= '0;
         display_q <= '0;
         strobe_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_in_q <= data_in_d;
         display_q <= display_d;
         strobe_q  <= strobe_d;
      end
   end

   assign data_in       = data_in_q;
   assign display       = display_q;
   assign output_strobe = strobe_q;

endmodule

// File: doc/io_unit.md
IO_UNIT -- requirements
Module: io_unit

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, the number of consecutive stable synchronized samples needed to accept a button level change.
REQ-002 The block SHALL have parameter SW_WIDTH, default 16, the width of the switch bank.
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 FLAG_input  input  1  from control unit; the current instruction is IN.
REQ-006 FLAG_output  input  1  from control unit; the current instruction is OUT.
REQ-007 data_out  input  32  R[rs] value to be displayed.
REQ-008 switches  input  SW_WIDTH  board switches, asynchronous, quasi-static.
REQ-009 confirm  input  1  raw confirm button, active-high, asynchronous, bouncing.
REQ-010 data_in  output  32  captured input value, to the register-file write mux (input leg).
REQ-011 stall  output  1  freezes PC and suppresses register and memory writes while high.
REQ-012 display  output  32  last value written by OUT.
REQ-013 output_strobe  output  1  one-cycle pulse when display updates.

Function
REQ-014 confirm SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 The debouncer SHALL count cycles in which the synchronized level differs from the debounced level, clearing the count whenever they match.
REQ-016 The debounced level SHALL take the synchronized value at the edge where the count equals DEBOUNCE_CYCLES-1, and the count SHALL clear at that edge.
REQ-017 The FSM SHALL have states IDLE, WAIT_PRESS, WAIT_RELEASE and DONE.
REQ-018 IDLE SHALL go to WAIT_PRESS when FLAG_input=1, otherwise remain in IDLE.
REQ-019 WAIT_PRESS SHALL go to WAIT_RELEASE when the debounced level is 1, loading data_in with {zeros, switches} zero-extended to 32 bits at that edge.
REQ-020 WAIT_RELEASE SHALL go to DONE when the debounced level is 0.
REQ-021 DONE SHALL go to IDLE unconditionally.
REQ-022 stall SHALL equal FLAG_input AND (state != DONE), combinationally, and SHALL be forced to 0 while reset=1.
REQ-023 In DONE, stall SHALL be 0 for exactly one cycle, so the CPU writes data_in to R[rd] and advances PC.
REQ-024 Back-to-back IN instructions SHALL each require a separate press-release sequence.
REQ-025 A button already held when IN issues SHALL be captured only after the FSM reaches WAIT_PRESS with the debounced level at 1; no re-press is required.
REQ-026 When FLAG_output=1, FLAG_input=0 and stall=0, display SHALL load data_out at the clock edge, and output_strobe SHALL be 1 in the following cycle only.
REQ-027 If FLAG_input and FLAG_output are both 1, the input path SHALL take priority and OUT SHALL be ignored.
REQ-028 data_in SHALL hold its value until the next capture.
REQ-029 The debouncer SHALL run continuously, independent of FSM state.

Reset
REQ-030 While reset=1, state SHALL be IDLE; data_in, display, output_strobe, synchronizer flops, debounce count and debounced level SHALL be 0.
REQ-031 Reset asserted mid-sequence SHALL abort the capture with no write; if FLAG_input=1 after reset release, a fresh WAIT_PRESS SHALL begin.

Structure
REQ-032 The FSM state encoding and the 32-bit data width constant SHALL live in the shared package mips_pkg.
REQ-033 Synchronizer and debounce counter SHALL form one sub-module, debouncer, parameterized by DEBOUNCE_CYCLES.
REQ-034 The debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES)+1.

Verification (DEBOUNCE_CYCLES=4, SW_WIDTH=16)
REQ-035 Reset, then idle 10 cycles -> display=0, data_in=0, stall=0, output_strobe=0.
REQ-036 FLAG_input=1, switches=16'hBEEF, confirm rises at edge 0 -> stall=1 continuously; data_in=32'h0000BEEF loaded at edge 7; confirm falls -> DONE with stall=0 for exactly one cycle, then IDLE.
REQ-037 FLAG_input=1, confirm toggles every 2 cycles for 20 cycles, then held high -> no capture during toggling; exactly one capture after the stable hold.
REQ-038 FLAG_output=1, data_out=32'h12345678 -> display=32'h12345678 after one edge; output_strobe high one cycle; FLAG_output and FLAG_input both 1 -> display unchanged.
REQ-039 reset pulsed while in WAIT_RELEASE -> state IDLE, data_in=0, stall=0 during reset; FLAG_input held -> stall=1 again the cycle after release.
REQ-040 Two consecutive IN instructions with press/release values 16'h0001 then 16'h0002 -> data_in=1 then 2, two DONE cycles, stall high between them.
